sum_checker: RTL and testbench
==============================

# sum_checker

Synthesizable result monitor for the register/adder datapath. It samples the operand pair `a`, `b` and the claimed sum `c` whenever `in_valid` is high. It checks `c == a + b` (mod 2^WIDTH) through a two-stage pipeline, counts checked and failing samples, and latches the first failing triple for readout. It sits beside `top` in simulation and on the board, consuming `top`'s outputs, so a run can be judged pass/fail without reading `$display` logs.

## Interface
Parameters:
- `WIDTH`, 32: operand and sum width.
- `CNT_W`, 16: width of both counters; counters saturate.
- `STOP_ON_ERR`, 0: when 1, the block enters HALT on the first mismatch and ignores further samples.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset; one clock; reset is synchronous and active-low.
- `in_valid`  in  1: sample `a`/`b`/`c` this cycle.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B.
- `c`  in  WIDTH: claimed sum.
- `clear`  in  1: synchronous soft clear of counters, capture and FSM.
- `chk_cnt`  out  CNT_W: number of compared samples.
- `err_cnt`  out  CNT_W: number of mismatching samples.
- `err_flag`  out  1: sticky; high once any mismatch is recorded.
- `first_a`  out  WIDTH: `a` of the first mismatch.
- `first_b`  out  WIDTH: `b` of the first mismatch.
- `first_c`  out  WIDTH: `c` of the first mismatch.
- `halted`  out  1: FSM is in HALT.
- `busy`  out  1: a sample is in flight in the pipeline.

## Operation
- Stage 1 (S1): on `in_valid` while accepting, register `a`, `b`, `c` and set `v1`.
- Stage 2 (S2): compute `sum = a + b` truncated to WIDTH bits; the carry-out is discarded and is never an error. Set `mis = (sum != c)` and register it with the triple and `v2`.
- Update at `v2`: increment `chk_cnt`. If `mis`, increment `err_cnt` and set `err_flag`.
- First-mismatch capture: on the first `v2 && mis` after reset or clear, load `first_a`/`first_b`/`first_c`. Later mismatches never overwrite the capture.
- Saturation: each counter holds at all-ones. It never wraps.
- FSM states:
  - IDLE: reset state. The first accepted `in_valid` moves to RUN in the same edge.
  - RUN: accepts samples.
  - HALT: entered on the edge where `v2 && mis && STOP_ON_ERR`. New samples are not accepted. HALT is left only by `clear` or reset.
  - With `STOP_ON_ERR=0`, HALT is unreachable.
- Accepting means state is IDLE or RUN.
- HALT and the pipeline: samples already in S1 when HALT is entered are discarded and not counted.
- Priority, highest first:
  1. `rst_n` low.
  2. `clear`.
  3. Normal operation.
- `clear` behaviour: zero both counters, `err_flag` and the capture; invalidate `v1`/`v2`; return to IDLE. An `in_valid` in the same cycle as `clear` is dropped.
- `busy = v1 | v2`.

## Timing
- All outputs are registered.
- Reset values (applied at the first rising edge with `rst_n` low):
  - `chk_cnt=0`, `err_cnt=0`, `err_flag=0`.
  - `first_a/b/c=0`.
  - `halted=0`, `busy=0`.
  - FSM in IDLE, `v1=v2=0`.
- Latency: a sample accepted at edge N appears in `chk_cnt`/`err_cnt`/`err_flag`/capture after edge N+2.
- HALT: `halted` rises after the same edge N+2.
- Throughput: one sample per cycle, no backpressure.
- Reset or clear mid-pipeline: in-flight samples are lost and not counted.
- Back-to-back mismatches at N and N+1: `err_cnt` increments on consecutive edges; the capture holds sample N.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles with `in_valid=1` -> all outputs 0, `busy=0`.
- Valid stream: 20 consecutive samples (a=1,b=1,c=2 / a=1,b=2,c=3 / … Fibonacci) -> `chk_cnt=20`, `err_cnt=0`, `err_flag=0`; first count visible 2 cycles after the first sample.
- Overflow is not an error: a=32'hFFFF_FFFF, b=1, c=0 -> counted, no error.
- Mismatch capture: (a=3,b=4,c=8) at edge N, then (5,5,11) at N+1, `STOP_ON_ERR=0` -> `err_cnt=2` and `first_*=3/4/8` after N+3.
- Halt: `STOP_ON_ERR=1`, same two samples -> `halted=1` after N+2, `chk_cnt=1`, `err_cnt=1`; later inputs ignored. Then `clear` -> IDLE, all zero; the next valid sample is counted.
- Saturation and clear race: with `CNT_W=4`, 20 valid samples -> `chk_cnt=15`. Assert `clear` with `in_valid=1` -> that sample is dropped, counters 0.

Source files
------------

// File: rtl/sum_checker.sv
// sum_checker: result monitor for the register/adder datapath.
//
// Samples (a, b, c) on in_valid and checks c == a + b (mod 2^WIDTH) through a
// two-stage pipeline. Counts checked and failing samples (saturating), keeps a
// sticky error flag, and latches the first failing triple. With STOP_ON_ERR=1
// the block halts on the first mismatch and ignores further samples until
// clear or reset.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   synchronous active-low reset
//   in_valid  in   sample a/b/c this cycle
//   a, b      in   operands (WIDTH)
//   c         in   claimed sum (WIDTH)
//   clear     in   synchronous soft clear of counters, capture and FSM
//   chk_cnt   out  number of compared samples (CNT_W, saturating)
//   err_cnt   out  number of mismatching samples (CNT_W, saturating)
//   err_flag  out  sticky mismatch flag
//   first_a/b/c out first mismatching triple
//   halted    out  FSM is in HALT
//   busy      out  a sample is in flight in the pipeline
module sum_checker #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             clear,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic [WIDTH-1:0] first_c,
    output logic             halted,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;

    // Stage 1: raw sample
    logic             v1_r;
    logic [WIDTH-1:0] a1_r;
    logic [WIDTH-1:0] b1_r;
    logic [WIDTH-1:0] c1_r;

    // Stage 2: sample plus registered compare result
    logic             v2_r;
    logic             mis_r;
    logic [WIDTH-1:0] a2_r;
    logic [WIDTH-1:0] b2_r;
    logic [WIDTH-1:0] c2_r;

    logic [WIDTH-1:0] sum_s;
    logic             halt_now_s;
    logic             accept_s;
    logic             v1_next_s;
    logic             v2_next_s;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (&val) begin
            res = val;
        end else begin
            res = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // Next-state decode: accept gating, halt detection and pipeline advance.
    always_comb begin
        // Carry-out is dropped by the WIDTH-bit assignment; overflow is legal.
        sum_s      = a1_r + b1_r;
        halt_now_s = v2_r && mis_r && STOP_ON_ERR;
        // The halting edge already refuses new samples.
        accept_s   = in_valid && (state_r != ST_HALT) && !halt_now_s;
        v1_next_s  = accept_s;
        // The sample sitting in S1 when HALT is entered is discarded.
        v2_next_s  = v1_r && !halt_now_s;

        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (halt_now_s) begin
                    state_next_s = ST_HALT;
                end else if (accept_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt_now_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, pipeline, counters, capture and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_r  <= ST_IDLE;
            v1_r     <= 1'b0;
            v2_r     <= 1'b0;
            mis_r    <= 1'b0;
            a1_r     <= '0;
            b1_r     <= '0;
            c1_r     <= '0;
            a2_r     <= '0;
            b2_r     <= '0;
            c2_r     <= '0;
            chk_cnt  <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            first_a  <= '0;
            first_b  <= '0;
            first_c  <= '0;
            halted   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            halted  <= (state_next_s == ST_HALT);
            busy    <= v1_next_s | v2_next_s;
            v1_r    <= v1_next_s;
            v2_r    <= v2_next_s;

            if (accept_s) begin
                a1_r <= a;
                b1_r <= b;
                c1_r <= c;
            end

            if (v1_r) begin
                a2_r  <= a1_r;
                b2_r  <= b1_r;
                c2_r  <= c1_r;
                mis_r <= (sum_s != c1_r);
            end

            if (v2_r) begin
                chk_cnt <= sat_inc(chk_cnt);
                if (mis_r) begin
                    err_cnt  <= sat_inc(err_cnt);
                    err_flag <= 1'b1;
                    // Only the first mismatch since reset/clear is captured.
                    if (!err_flag) begin
                        first_a <= a2_r;
                        first_b <= b2_r;
                        first_c <= c2_r;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sum_checker.sv
// Testbench for sum_checker: three instances (free-running, stop-on-error,
// 4-bit counters) share one stimulus stream. Stimulus pushes expected samples
// into a scoreboard queue tagged with the edge at which they become visible;
// a monitor pops them, advances a behavioural model and compares all outputs.
module tb_sum_checker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        clear;

    logic [15:0] chk0, err0, chk1, err1;
    logic [3:0]  chk2, err2;
    logic        flag0, flag1, flag2;
    logic [31:0] fa0, fb0, fc0, fa1, fb1, fc1, fa2, fb2, fc2;
    logic        halt0, halt1, halt2;
    logic        busy0, busy1, busy2;

    sum_checker #(.WIDTH(32), .CNT_W(16), .STOP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .clear(clear), .chk_cnt(chk0), .err_cnt(err0), .err_flag(flag0),
        .first_a(fa0), .first_b(fb0), .first_c(fc0), .halted(halt0), .busy(busy0)
    );

    sum_checker #(.WIDTH(32), .CNT_W(16), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .clear(clear), .chk_cnt(chk1), .err_cnt(err1), .err_flag(flag1),
        .first_a(fa1), .first_b(fb1), .first_c(fc1), .halted(halt1), .busy(busy1)
    );

    sum_checker #(.WIDTH(32), .CNT_W(4), .STOP_ON_ERR(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .clear(clear), .chk_cnt(chk2), .err_cnt(err2), .err_flag(flag2),
        .first_a(fa2), .first_b(fb2), .first_c(fc2), .halted(halt2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] sa;
        logic [31:0] sb;
        logic [31:0] sc;
    } ent_t;

    ent_t sq[$];
    int   clr_due[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit checks_on = 1'b0;

    // Behavioural model per instance
    int          m_chk[3];
    int          m_err[3];
    bit          m_flag[3];
    bit          m_halt[3];
    logic [31:0] m_fa[3];
    logic [31:0] m_fb[3];
    logic [31:0] m_fc[3];
    int          cmax[3] = '{65535, 65535, 15};
    bit          stop[3] = '{1'b0, 1'b1, 1'b0};

    task automatic cmp(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic model_zero();
        for (int k = 0; k < 3; k++) begin
            m_chk[k] = 0; m_err[k] = 0; m_flag[k] = 1'b0; m_halt[k] = 1'b0;
            m_fa[k] = 32'h0; m_fb[k] = 32'h0; m_fc[k] = 32'h0;
        end
    endtask

    task automatic model_apply(input ent_t e);
        logic [31:0] s;
        bit mis;
        s   = e.sa + e.sb;
        mis = (s != e.sc);
        for (int k = 0; k < 3; k++) begin
            if (!m_halt[k]) begin
                if (m_chk[k] < cmax[k]) m_chk[k]++;
                if (mis) begin
                    if (m_err[k] < cmax[k]) m_err[k]++;
                    if (!m_flag[k]) begin
                        m_fa[k] = e.sa; m_fb[k] = e.sb; m_fc[k] = e.sc;
                    end
                    m_flag[k] = 1'b1;
                    if (stop[k]) m_halt[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_dut(input int k, input logic [15:0] ch, input logic [15:0] er,
                             input logic fl, input logic [31:0] xa, input logic [31:0] xb,
                             input logic [31:0] xc, input logic hl, input logic bs);
        bit pend;
        pend = (sq.size() > 0);
        cmp("chk_cnt", k, {48'h0, ch}, m_chk[k]);
        cmp("err_cnt", k, {48'h0, er}, m_err[k]);
        cmp("err_flag", k, {63'h0, fl}, {63'h0, m_flag[k]});
        cmp("first_a", k, {32'h0, xa}, {32'h0, m_fa[k]});
        cmp("first_b", k, {32'h0, xb}, {32'h0, m_fb[k]});
        cmp("first_c", k, {32'h0, xc}, {32'h0, m_fc[k]});
        cmp("halted", k, {63'h0, hl}, {63'h0, m_halt[k]});
        cmp("busy", k, {63'h0, bs}, {63'h0, (pend && !m_halt[k])});
    endtask

    // Monitor: retire scoreboard entries due at this edge, then compare.
    always @(posedge clk) begin
        #1;
        if (clr_due.size() > 0 && clr_due[0] == cyc) begin
            void'(clr_due.pop_front());
            sq.delete();
            model_zero();
            checks_on = 1'b1;
        end else begin
            while (sq.size() > 0 && sq[0].due == cyc) begin
                model_apply(sq.pop_front());
            end
        end
        if (checks_on) begin
            check_dut(0, chk0, err0, flag0, fa0, fb0, fc0, halt0, busy0);
            check_dut(1, chk1, err1, flag1, fa1, fb1, fc1, halt1, busy1);
            check_dut(2, {12'h0, chk2}, {12'h0, err2}, flag2, fa2, fb2, fc2, halt2, busy2);
        end
    end

    // Drive one cycle of inputs and record the expected effect.
    task automatic step(input bit v, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [31:0] tc, input bit clr, input bit rn);
        ent_t e;
        @(negedge clk);
        in_valid = v; a = ta; b = tb_; c = tc; clear = clr; rst_n = rn;
        if (!rn || clr) begin
            clr_due.push_back(cyc + 1);
        end else if (v) begin
            e.due = cyc + 3;
            e.sa = ta; e.sb = tb_; e.sc = tc;
            sq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    logic [31:0] fa, fb, ft, ra, rb, rc;
    bit          rv, rclr;

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; clear = 1'b0;
        a = 32'h0; b = 32'h0; c = 32'h0;

        // Reset held two cycles with in_valid asserted
        step(1'b1, 32'h5, 32'h6, 32'h7, 1'b0, 1'b0);
        step(1'b1, 32'h5, 32'h6, 32'h7, 1'b0, 1'b0);
        idle(2);

        // Fibonacci valid stream; 4-bit instance saturates at 15
        fa = 32'h1; fb = 32'h1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, fa, fb, fa + fb, 1'b0, 1'b1);
            ft = fa + fb; fa = fb; fb = ft;
        end
        idle(3);

        // Carry-out is not an error
        step(1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1);
        idle(3);

        // Back-to-back mismatches; stop-on-error instance halts
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'd3, 32'd4, 32'd8, 1'b0, 1'b1);
        step(1'b1, 32'd5, 32'd5, 32'd11, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 32'd10 + i, 32'd1, 32'd11 + i, 1'b0, 1'b1);
        idle(3);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'd7, 32'd8, 32'd15, 1'b0, 1'b1);
        idle(3);

        // Clear racing a valid sample: the sample is dropped
        step(1'b1, 32'd1, 32'd2, 32'd9, 1'b1, 1'b1);
        idle(3);

        // Randomized traffic with occasional corruption and clears
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = $urandom;
            rc = ra + rb;
            if ($urandom_range(0, 7) == 0) rc = rc ^ (32'h1 << $urandom_range(0, 31));
            rclr = ($urandom_range(0, 39) == 0);
            step(rv, ra, rb, rc, rclr, 1'b1);
        end
        idle(4);

        n_tests++;
        if (sq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
